// File: rtl/handshake_rx_pkg.sv
// Shared types and width helpers for the pin-side handshake receiver.
package handshake_rx_pkg;

    typedef enum logic {HS_IDLE, HS_ACK} hs_state_t;

    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A disabled timeout still needs a legal one-bit counter declaration.
    function automatic int tmo_w(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/hs_fifo.sv
// Small synchronous FIFO with registered count; head is read straight from storage.
module hs_fifo
    import handshake_rx_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    localparam int CNT_W = count_w(DEPTH),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage is cleared on reset so the head reads zero until the first write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + PTR_W'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/handshake_rx.sv
// Receives words over an asynchronous 4-phase req/ack pin handshake and
// queues them for a ready/valid consumer.
module handshake_rx
    import handshake_rx_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int SIDE_W         = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_req,
    input  logic [DATA_W-1:0]                 in_data,
    input  logic [SIDE_W-1:0]                 in_side,
    output logic                              in_ack,
    input  logic                              enable,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_W-1:0]                 out_data,
    output logic [SIDE_W-1:0]                 out_side,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              hs_timeout
);

    localparam int TMO_W = tmo_w(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    hs_state_t              state;
    hs_state_t              state_next;
    logic                   ack_next;
    logic                   capture;
    logic                   fifo_full;
    logic                   fifo_empty;

    // in_req is only ever observed through this chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_req};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_next = state;
        ack_next   = 1'b0;
        capture    = 1'b0;
        case (state)
            HS_IDLE: begin
                if (req_s && enable && !fifo_full) begin
                    capture    = 1'b1;
                    ack_next   = 1'b1;
                    state_next = HS_ACK;
                end
            end
            HS_ACK: begin
                if (req_s) begin
                    ack_next = 1'b1;
                end else begin
                    state_next = HS_IDLE;
                end
            end
            default: state_next = HS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= HS_IDLE;
            in_ack <= 1'b0;
        end else begin
            state  <= state_next;
            in_ack <= ack_next;
        end
    end

    // Pin data is bundled with req, so it is sampled directly at the capture edge.
    hs_fifo #(
        .WIDTH (DATA_W + SIDE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .pop   (out_ready),
        .flush (flush),
        .wdata ({in_side, in_data}),
        .rdata ({out_side, out_data}),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;

    if (TIMEOUT_CYCLES == 0) begin : g_no_tmo
        assign hs_timeout = 1'b0;
    end else begin : g_tmo
        localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

        logic [TMO_W-1:0] tmo_cnt;
        logic             tmo_flag;
        logic             tmo_incr;
        logic             tmo_hit;

        assign tmo_incr = (state == HS_ACK) && req_s && (tmo_cnt != TMO_MAX);
        // Set only on the step into saturation so a flush mid-ACK stays cleared.
        assign tmo_hit  = tmo_incr && (tmo_cnt == TMO_MAX - TMO_W'(1));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tmo_cnt  <= '0;
                tmo_flag <= 1'b0;
            end else begin
                if (capture) begin
                    tmo_cnt <= '0;
                end else if (tmo_incr) begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
                if (flush) begin
                    tmo_flag <= 1'b0;
                end else if (tmo_hit) begin
                    tmo_flag <= 1'b1;
                end
            end
        end

        assign hs_timeout = tmo_flag;
    end

endmodule

// File: tb/tb_handshake_rx.sv
// Bench for handshake_rx: cycle vector table, directed corner sequences and a
// randomized sender/consumer checked against a queue model.
module tb_handshake_rx;

    localparam int DATA_W         = 8;
    localparam int SIDE_W         = 2;
    localparam int SYNC_STAGES    = 2;
    localparam int FIFO_DEPTH     = 4;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int CNT_W          = $clog2(FIFO_DEPTH + 1);
    localparam int RND_WORDS      = 150;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_req = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [SIDE_W-1:0] in_side = '0;
    logic              in_ack;
    logic              enable = 1'b0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [SIDE_W-1:0] out_side;
    logic [CNT_W-1:0]  fifo_count;
    logic              hs_timeout;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W+SIDE_W-1:0] exp_q[$];

    typedef struct {
        logic              req;
        logic [DATA_W-1:0] data;
        logic [SIDE_W-1:0] side;
        logic              en;
        logic              rdy;
        logic              exp_ack;
        logic              exp_valid;
        logic [CNT_W-1:0]  exp_cnt;
        logic [DATA_W-1:0] exp_data;
        logic [SIDE_W-1:0] exp_side;
    } vec_t;

    vec_t vecs[$];

    handshake_rx #(
        .DATA_W         (DATA_W),
        .SIDE_W         (SIDE_W),
        .SYNC_STAGES    (SYNC_STAGES),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_req     (in_req),
        .in_data    (in_data),
        .in_side    (in_side),
        .in_ack     (in_ack),
        .enable     (enable),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_side   (out_side),
        .fifo_count (fifo_count),
        .hs_timeout (hs_timeout)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ack(input logic level, input string name);
        int n;
        n = 0;
        while (in_ack !== level && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(in_ack), 32'(level));
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input logic [SIDE_W-1:0] s);
        in_data = d;
        in_side = s;
        in_req  = 1'b1;
        wait_ack(1'b1, "send_ack_rise");
        in_req = 1'b0;
        wait_ack(1'b0, "send_ack_fall");
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic add_vec(input logic req, input logic [DATA_W-1:0] data, input logic [SIDE_W-1:0] side,
                           input logic en, input logic rdy, input logic e_ack, input logic e_valid,
                           input logic [CNT_W-1:0] e_cnt, input logic [DATA_W-1:0] e_data,
                           input logic [SIDE_W-1:0] e_side);
        vec_t v;
        v.req = req; v.data = data; v.side = side; v.en = en; v.rdy = rdy;
        v.exp_ack = e_ack; v.exp_valid = e_valid; v.exp_cnt = e_cnt;
        v.exp_data = e_data; v.exp_side = e_side;
        vecs.push_back(v);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [DATA_W+SIDE_W-1:0] cur;
        logic [DATA_W+SIDE_W-1:0] got;
        int  pops;
        int  sent;
        int  cyc;
        int  phase;
        int  dly;
        int  n;
        logic prev_ack;
        bit  pop_pending;

        // Reset
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(in_ack), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_side", 32'(out_side), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_timeout", 32'(hs_timeout), 0);
        rst = 1'b0;
        enable = 1'b1;

        // Cycle table: single word latency, one-cycle valid pulse, ack release,
        // enable gating then immediate capture.
        for (int i = 0; i < 3; i++) add_vec(1, 8'hA5, 2'b01, 1, 1, (i == 2), (i == 2), (i == 2) ? 1 : 0, 8'hA5, 2'b01);
        add_vec(1, 8'hA5, 2'b01, 1, 1, 1, 0, 0, 8'h00, 2'b00);
        add_vec(0, 8'hA5, 2'b01, 1, 1, 1, 0, 0, 8'h00, 2'b00);
        add_vec(0, 8'hA5, 2'b01, 1, 1, 1, 0, 0, 8'h00, 2'b00);
        add_vec(0, 8'hA5, 2'b01, 1, 1, 0, 0, 0, 8'h00, 2'b00);
        for (int i = 0; i < 10; i++) add_vec(1, 8'h3C, 2'b10, 0, 0, 0, 0, 0, 8'h00, 2'b00);
        add_vec(1, 8'h3C, 2'b10, 1, 0, 1, 1, 1, 8'h3C, 2'b10);
        add_vec(0, 8'h3C, 2'b10, 1, 0, 1, 1, 1, 8'h3C, 2'b10);
        add_vec(0, 8'h3C, 2'b10, 1, 0, 1, 1, 1, 8'h3C, 2'b10);
        add_vec(0, 8'h3C, 2'b10, 1, 0, 0, 1, 1, 8'h3C, 2'b10);
        add_vec(0, 8'h3C, 2'b10, 1, 1, 0, 0, 0, 8'h00, 2'b00);

        foreach (vecs[i]) begin
            in_req = vecs[i].req;
            in_data = vecs[i].data;
            in_side = vecs[i].side;
            enable = vecs[i].en;
            out_ready = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d_ack", i), 32'(in_ack), 32'(vecs[i].exp_ack));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_cnt));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_data", i), 32'({out_side, out_data}),
                      32'({vecs[i].exp_side, vecs[i].exp_data}));
            end
        end

        // Back-pressure: four words fill the FIFO, the fifth waits for a pop.
        enable = 1'b1;
        out_ready = 1'b0;
        exp_q.delete();
        for (int i = 1; i <= 5; i++) exp_q.push_back({SIDE_W'(i), DATA_W'(i)});
        for (int i = 1; i <= 4; i++) send_word(DATA_W'(i), SIDE_W'(i));
        check("bp_full_count", 32'(fifo_count), 4);
        in_data = 8'h05;
        in_side = 2'b01;
        in_req = 1'b1;
        repeat (10) tick();
        check("bp_fifth_blocked", 32'(in_ack), 0);
        check("bp_count_held", 32'(fifo_count), 4);
        out_ready = 1'b1;
        pops = 0;
        n = 0;
        while ((exp_q.size() != 0 || in_req || in_ack) && n < 60) begin
            if (out_valid && exp_q.size() != 0) begin
                got = exp_q.pop_front();
                check("bp_pop_data", 32'({out_side, out_data}), 32'(got));
                pops++;
            end
            if (in_ack && in_req) begin
                check("bp_ack_after_pop", 32'(pops >= 1), 1);
                in_req = 1'b0;
            end
            tick();
            n++;
        end
        check("bp_words_left", 32'(exp_q.size()), 0);
        check("bp_drained_count", 32'(fifo_count), 0);

        // Simultaneous push and pop at count 2, then pops on an empty FIFO.
        out_ready = 1'b0;
        send_word(8'h11, 2'b01);
        send_word(8'h22, 2'b10);
        check("pp_count_before", 32'(fifo_count), 2);
        in_data = 8'h33;
        in_side = 2'b11;
        in_req = 1'b1;
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pp_count_same", 32'(fifo_count), 2);
        check("pp_ack", 32'(in_ack), 1);
        check("pp_head", 32'({out_side, out_data}), 32'({2'b10, 8'h22}));
        in_req = 1'b0;
        wait_ack(1'b0, "pp_ack_fall");
        out_ready = 1'b1;
        check("pp_order_1", 32'({out_side, out_data}), 32'({2'b10, 8'h22}));
        tick();
        check("pp_order_2", 32'({out_side, out_data}), 32'({2'b11, 8'h33}));
        check("pp_valid_2", 32'(out_valid), 1);
        tick();
        repeat (3) tick();
        check("pp_empty_pop_count", 32'(fifo_count), 0);
        check("pp_empty_pop_valid", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Timeout: hold req after ack.
        in_data = 8'h77;
        in_side = 2'b00;
        in_req = 1'b1;
        wait_ack(1'b1, "to_ack_rise");
        repeat (6) tick();
        check("to_not_yet", 32'(hs_timeout), 0);
        repeat (2) tick();
        check("to_set", 32'(hs_timeout), 1);
        in_req = 1'b0;
        wait_ack(1'b0, "to_ack_fall");
        check("to_sticky", 32'(hs_timeout), 1);
        check("to_count", 32'(fifo_count), 1);
        pulse_flush();
        check("to_flush_clear", 32'(hs_timeout), 0);
        check("to_flush_count", 32'(fifo_count), 0);
        check("to_flush_valid", 32'(out_valid), 0);

        // Capture coinciding with flush: acknowledged but discarded.
        in_data = 8'h55;
        in_side = 2'b01;
        in_req = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fc_ack", 32'(in_ack), 1);
        check("fc_count", 32'(fifo_count), 0);
        in_req = 1'b0;
        wait_ack(1'b0, "fc_ack_fall");
        check("fc_count_after", 32'(fifo_count), 0);

        // Asynchronous reset during ACK with two words queued.
        send_word(8'h41, 2'b01);
        in_data = 8'h42;
        in_side = 2'b10;
        in_req = 1'b1;
        wait_ack(1'b1, "ra_ack_rise");
        check("ra_count_before", 32'(fifo_count), 2);
        #2 rst = 1'b1;
        #1;
        check("ra_ack", 32'(in_ack), 0);
        check("ra_valid", 32'(out_valid), 0);
        check("ra_count", 32'(fifo_count), 0);
        check("ra_timeout", 32'(hs_timeout), 0);
        check("ra_data", 32'(out_data), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check("ra_recap_early", 32'(in_ack), 0);
        tick();
        check("ra_recap_ack", 32'(in_ack), 1);
        check("ra_recap_count", 32'(fifo_count), 1);
        check("ra_recap_data", 32'({out_side, out_data}), 32'({2'b10, 8'h42}));
        in_req = 1'b0;
        wait_ack(1'b0, "ra_ack_fall");
        pulse_flush();

        // Randomized traffic against a word-order queue model.
        exp_q.delete();
        sent = 0;
        cyc = 0;
        phase = 0;
        dly = 0;
        prev_ack = in_ack;
        pop_pending = 1'b0;
        cur = '0;
        while (sent < RND_WORDS && cyc < 15000) begin
            if (pop_pending) begin
                void'(exp_q.pop_front());
                pop_pending = 1'b0;
            end
            if (in_ack && !prev_ack) exp_q.push_back(cur);
            prev_ack = in_ack;
            check("rnd_count", 32'(fifo_count), 32'(exp_q.size()));
            check("rnd_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("rnd_timeout", 32'(hs_timeout), 0);
            out_ready = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 4) != 0);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                check("rnd_data", 32'({out_side, out_data}), 32'(exp_q[0]));
                pop_pending = 1'b1;
            end
            case (phase)
                0: begin
                    if (dly == 0) begin
                        cur = (DATA_W + SIDE_W)'($urandom());
                        {in_side, in_data} = cur;
                        in_req = 1'b1;
                        phase = 1;
                    end else begin
                        dly--;
                        in_data = DATA_W'($urandom());
                    end
                end
                1: begin
                    if (in_ack) begin
                        in_req = 1'b0;
                        in_data = DATA_W'($urandom());
                        in_side = SIDE_W'($urandom());
                        phase = 2;
                    end
                end
                default: begin
                    if (!in_ack) begin
                        sent++;
                        dly = $urandom_range(0, 3);
                        phase = 0;
                    end
                end
            endcase
            tick();
            cyc++;
        end
        check("rnd_all_sent", 32'(sent), RND_WORDS);
        if (pop_pending) void'(exp_q.pop_front());
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            got = exp_q.pop_front();
            check("rnd_drain_data", 32'({out_side, out_data}), 32'(got));
            tick();
            n++;
        end
        check("rnd_drain_count", 32'(fifo_count), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/handshake_rx.md
Name: handshake_rx

Overview:
Parametrised successor to the stream-cipher pin reader. It receives bundled data from chip pins over an asynchronous 4-phase req/ack handshake, synchronises req, and captures data plus sideband flags (e.g. is_key, reset_hash) into a small FIFO. The FIFO drains to the data router over a ready/valid interface; tying out_ready high yields one single-cycle pulse per word. Adds back-pressure, flush, enable gating and a handshake timeout flag.

Parameters:
DATA_W, 8, width of in_data/out_data
SIDE_W, 2, width of sideband flags travelling with each word
SYNC_STAGES, 2, req synchroniser depth (>=2)
FIFO_DEPTH, 4, word buffer depth (power of 2, >=2)
TIMEOUT_CYCLES, 1024, max cycles in ACK phase before flagging (0 disables)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
in_req  in  1  pin request, asynchronous to clk
in_data  in  DATA_W  pin data, stable while in_req high
in_side  in  SIDE_W  pin sideband, stable while in_req high
in_ack  out  1  pin acknowledge, registered
enable  in  1  permits new captures (driven from FSM state logic)
flush  in  1  synchronous FIFO clear plus timeout clear
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_data  out  DATA_W  FIFO head data
out_side  out  SIDE_W  FIFO head sideband
fifo_count  out  $clog2(FIFO_DEPTH+1)  words held
hs_timeout  out  1  sticky timeout flag

Behaviour:
- Reset: in_ack=0, out_valid=0, out_data=0, out_side=0, fifo_count=0, hs_timeout=0. Synchroniser flops cleared. FSM enters IDLE. Reset mid-handshake drops in_ack immediately; a sender still holding req is re-captured after sync once IDLE conditions hold.
- req_s = last synchroniser stage. No other logic samples in_req directly.
- FSM IDLE:
  - Condition: req_s=1 && enable=1 && fifo_count<FIFO_DEPTH.
  - On that edge: write {in_side,in_data} (sampled directly from pins, bundled-data) into FIFO, set in_ack=1, go to ACK.
  - Otherwise hold, in_ack=0.
- FSM ACK: stay while req_s=1. On the first edge with req_s=0: in_ack=0, go to IDLE. Exactly one word per handshake; req must be seen low before the next capture.
- Latency: with in_req rising before edge 0, req_s is high after edge SYNC_STAGES-1. Capture occurs at edge SYNC_STAGES. in_ack and out_valid (if FIFO was empty) are high after that edge. in_ack falls SYNC_STAGES+1 edges after in_req falls.
- Full: capture is blocked while fifo_count==FIFO_DEPTH, including a cycle with a simultaneous pop (uses registered count). in_ack stays low, so the sender is back-pressured and there is no overflow.
- Pop: out_valid && out_ready advances the head. Pop when empty is ignored. Simultaneous push and pop leaves count unchanged. The FIFO is not fall-through: a word written at edge E is visible after E.
- enable=0: blocks new captures only. An ACK phase in progress completes normally.
- flush: has priority over push and pop in the same cycle. FIFO is emptied (pointers and count 0) and hs_timeout is cleared. The FSM is unaffected. A capture coinciding with flush is still acknowledged, but the word is discarded.
- Timeout:
  - Counter runs only in ACK while req_s=1 and resets on entry to ACK. Counter width is $clog2(TIMEOUT_CYCLES+1).
  - When the counter reaches TIMEOUT_CYCLES, hs_timeout is set and stays set until flush or rst. The counter saturates there.
  - The FSM keeps waiting for req low.
  - TIMEOUT_CYCLES=0: hs_timeout tied 0.
- Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.

Decomposition:
- Package handshake_rx_pkg holds:
  - typedef enum logic {HS_IDLE, HS_ACK} hs_state_t
  - width helper constants for count and timeout counter
- Natural sub-module: hs_fifo, a synchronous FIFO parametrised on width (DATA_W+SIDE_W) and depth, with push, pop, flush, count, head.
- The synchroniser and FSM stay in handshake_rx.

Test Plan:
- Single word, out_ready=1, in_req=1 with in_data=0xA5, in_side=2'b01 before edge 0 -> in_ack=1 and out_valid=1 after edge 2. out_valid pulses exactly 1 cycle with out_data=0xA5, out_side=01. Drop in_req -> in_ack=0 three edges later.
- Back-pressure, out_ready=0, send 5 words 0x01..0x05 (FIFO_DEPTH=4) -> fifo_count reaches 4 and the 5th in_ack stays low. Raise out_ready -> 0x01..0x05 pop in order, and the 5th is acknowledged after the first pop.
- Simultaneous push and pop at count=2 -> count stays 2 and data order is preserved. Pop when empty -> count stays 0.
- enable=0 with in_req high for 10 cycles -> no in_ack, count 0. Set enable=1 -> capture SYNC_STAGES... immediate (req_s already high): in_ack high after the next edge.
- Timeout with TIMEOUT_CYCLES=8: hold in_req high after ack -> hs_timeout=1 after 8 ACK cycles and stays set after in_req falls. Pulse flush -> hs_timeout=0 and count=0.
- Assert rst during ACK with 2 words queued -> in_ack, out_valid, fifo_count and hs_timeout are 0 immediately (asynchronously). Release rst with in_req still high -> the word is re-captured 2 edges later.
